// File: rtl/kes_pool_dispatcher_pkg.sv
// kes_pool_dispatcher_pkg: shared slot-state encoding and round-robin helper for the KES pool dispatcher.
//   Contents:
//     S_IDLE/S_ISSUE/S_DUMMY/S_STANDBY  one-hot slot state codes
//     slot_state_e                      enum built on those codes
//     MAX_CH/MAX_CW                     widest channel vector the picker handles
//     rr_pick(req, ptr)                 rotating priority pick, returns {valid, index}
package kes_pool_pkg;

    localparam logic [3:0] S_IDLE    = 4'b0001;
    localparam logic [3:0] S_ISSUE   = 4'b0010;
    localparam logic [3:0] S_DUMMY   = 4'b0100;
    localparam logic [3:0] S_STANDBY = 4'b1000;

    typedef enum logic [3:0] {
        ST_IDLE    = S_IDLE,
        ST_ISSUE   = S_ISSUE,
        ST_DUMMY   = S_DUMMY,
        ST_STANDBY = S_STANDBY
    } slot_state_e;

    localparam int MAX_CH = 8;
    localparam int MAX_CW = 3;

    // Narrower channel vectors are zero-extended; as long as ptr is below the
    // real channel count, the unused upper indices never win, so wrapping
    // modulo MAX_CH gives the same order as wrapping modulo the real count.
    function automatic logic [MAX_CW:0] rr_pick(input logic [MAX_CH-1:0] req,
                                                input logic [MAX_CW-1:0] ptr);
        logic [MAX_CW:0]   res;
        logic [MAX_CW-1:0] idx;
        res = '0;
        // Scan from the farthest offset down so the nearest one to ptr wins.
        for (int i = MAX_CH - 1; i >= 0; i--) begin
            idx = ptr + MAX_CW'(i);
            if (req[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

endpackage

// File: rtl/kes_pool_dispatcher_if.sv
// kes_pool_dispatcher_if: channel/KES handshake bundle between the syndrome calculators, the dispatcher and the KES array.
//   iRequestChannel [NUM_CH]      channel c has a chunk ready, held until granted
//   iLastChunk      [NUM_CH]      pending chunk of channel c is its last
//   iKESAvail       [NUM_KES]     KES k can accept a chunk
//   oGrant          [NUM_CH]      one-cycle pulse, chunk of channel c accepted
//   oKESStart       [NUM_KES]     one-cycle pulse, KES k loads its bound channel's chunk
//   oKESChannel     [NUM_KES*CW]  channel bound to KES k, slice k*CW +: CW
//   oKESBound       [NUM_KES]     KES k is bound
//   modport master: the driving side (channels + KES array); modport slave: the dispatcher
interface kes_pool_dispatcher_if #(
    parameter int NUM_CH  = 4,
    parameter int NUM_KES = 2
);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]      iRequestChannel;
    logic [NUM_CH-1:0]      iLastChunk;
    logic [NUM_KES-1:0]     iKESAvail;
    logic [NUM_CH-1:0]      oGrant;
    logic [NUM_KES-1:0]     oKESStart;
    logic [NUM_KES*CW-1:0]  oKESChannel;
    logic [NUM_KES-1:0]     oKESBound;

    modport master (
        output iRequestChannel, iLastChunk, iKESAvail,
        input  oGrant, oKESStart, oKESChannel, oKESBound
    );

    modport slave (
        input  iRequestChannel, iLastChunk, iKESAvail,
        output oGrant, oKESStart, oKESChannel, oKESBound
    );

endinterface

// File: rtl/kes_pool_dispatcher_slot.sv
// kes_slot_fsm: per-KES binding FSM (Idle/Issue/Dummy/Standby) holding the bound channel and last-chunk flag.
//   i_clock     clock, rising edge
//   i_reset_n   synchronous reset, active low
//   i_bind      allocator selects this slot this cycle (only while Idle)
//   i_bind_ch   channel being bound
//   i_avail     this KES can accept a chunk
//   i_req       request bit of the bound channel
//   i_last      last-chunk bit of the bound channel
//   o_start     start pulse to the KES (Issue state)
//   o_bound     slot is not Idle
//   o_ch        bound channel, kept after release until the next binding
module kes_slot_fsm
    import kes_pool_pkg::*;
#(
    parameter int CW = 2
) (
    input  logic          i_clock,
    input  logic          i_reset_n,
    input  logic          i_bind,
    input  logic [CW-1:0] i_bind_ch,
    input  logic          i_avail,
    input  logic          i_req,
    input  logic          i_last,
    output logic          o_start,
    output logic          o_bound,
    output logic [CW-1:0] o_ch
);

    slot_state_e   r_state;
    slot_state_e   w_next;
    logic          r_last;
    logic [CW-1:0] r_ch;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
            r_ch    <= '0;
        end else begin
            r_state <= w_next;
            if (i_bind) r_ch <= i_bind_ch;
            // The channel's last flag is only meaningful while its chunk is offered.
            if (r_state == ST_ISSUE) r_last <= i_last;
        end
    end

    always_comb begin
        w_next  = r_state;
        o_start = r_state == ST_ISSUE;
        o_bound = r_state != ST_IDLE;
        o_ch    = r_ch;
        case (r_state)
            ST_IDLE:    w_next = i_bind ? ST_ISSUE : ST_IDLE;
            ST_ISSUE:   w_next = ST_DUMMY;
            // Dummy absorbs the cycle in which the KES lowers its avail flag.
            ST_DUMMY:   w_next = r_last ? ST_IDLE : ST_STANDBY;
            ST_STANDBY: w_next = (i_avail && i_req) ? ST_ISSUE : ST_STANDBY;
            default:    w_next = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/kes_pool_dispatcher.sv
// kes_pool_dispatcher: binds requesting BCH channels to free KES units from a pool and issues their chunks.
//   iClock   clock, rising edge
//   iReset   synchronous reset, active low
//   bus      kes_pool_dispatcher_if.slave: channel requests/last flags and KES avail in;
//            grants, KES start pulses, bound channels and bound flags out
module kes_pool_dispatcher
    import kes_pool_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int NUM_KES = 2
) (
    input  logic                  iClock,
    input  logic                  iReset,
    kes_pool_dispatcher_if.slave  bus
);

    localparam int CW = $clog2(NUM_CH);

    logic [CW-1:0]      r_ptr;
    logic [CW-1:0]      w_ch [NUM_KES];
    logic [NUM_KES-1:0] w_start;
    logic [NUM_KES-1:0] w_bound;
    logic [NUM_KES-1:0] w_cand;
    logic [NUM_KES-1:0] w_bind;
    logic [NUM_CH-1:0]  w_bound_mask;
    logic [NUM_CH-1:0]  w_elig;
    logic [NUM_CH-1:0]  w_grant;
    logic               w_valid;
    logic [MAX_CW-1:0]  w_idx;
    logic [CW-1:0]      w_win;

    // Channel-side view: which channels are held, which slot is issuing for whom.
    always_comb begin
        w_bound_mask = '0;
        w_grant      = '0;
        for (int k = 0; k < NUM_KES; k++) begin
            if (w_bound[k]) w_bound_mask[w_ch[k]] = 1'b1;
            if (w_start[k]) w_grant[w_ch[k]]      = 1'b1;
        end
    end

    // Allocator: lowest idle-and-available slot takes the round-robin winner
    // among requesting channels not already held by some slot.
    always_comb begin
        w_elig           = bus.iRequestChannel & ~w_bound_mask;
        {w_valid, w_idx} = rr_pick(MAX_CH'(w_elig), MAX_CW'(r_ptr));
        w_win            = CW'(w_idx);
        w_cand           = ~w_bound & bus.iKESAvail;
        w_bind           = (w_cand & (~w_cand + NUM_KES'(1))) & {NUM_KES{w_valid}};
    end

    always_ff @(posedge iClock) begin
        if (!iReset)      r_ptr <= '0;
        else if (|w_bind) r_ptr <= w_win + CW'(1);
    end

    for (genvar k = 0; k < NUM_KES; k++) begin : g_slot
        kes_slot_fsm #(.CW(CW)) u_slot (
            .i_clock   (iClock),
            .i_reset_n (iReset),
            .i_bind    (w_bind[k]),
            .i_bind_ch (w_win),
            .i_avail   (bus.iKESAvail[k]),
            .i_req     (bus.iRequestChannel[w_ch[k]]),
            .i_last    (bus.iLastChunk[w_ch[k]]),
            .o_start   (w_start[k]),
            .o_bound   (w_bound[k]),
            .o_ch      (w_ch[k])
        );
        assign bus.oKESChannel[k*CW +: CW] = w_ch[k];
    end

    assign bus.oGrant    = w_grant;
    assign bus.oKESStart = w_start;
    assign bus.oKESBound = w_bound;

endmodule

// File: tb/tb_kes_pool_dispatcher.sv
// tb_kes_pool_dispatcher: directed-vector bench for the KES pool dispatcher with a per-channel chunk model.
module tb_kes_pool_dispatcher;

    logic       clk;
    logic       iReset;
    logic       rst_n;
    logic [1:0] av;
    logic       all_last;
    int         rem [4];
    logic [3:0] g;
    logic [1:0] st;
    logic [3:0] chs;
    logic [1:0] bd;
    int         n_vec;
    int         n_err;

    kes_pool_dispatcher_if #(.NUM_CH(4), .NUM_KES(2)) bus ();

    kes_pool_dispatcher #(.NUM_CH(4), .NUM_KES(2)) dut (
        .iClock (clk),
        .iReset (iReset),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One cycle: drive this cycle's inputs from the channel model, sample the
    // registered outputs, then retire any chunk granted in this cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        iReset        = rst_n;
        bus.iKESAvail = av;
        for (int c = 0; c < 4; c++) begin
            bus.iRequestChannel[c] = rem[c] > 0;
            bus.iLastChunk[c]      = all_last || rem[c] == 1;
        end
        g   = bus.oGrant;
        st  = bus.oKESStart;
        chs = bus.oKESChannel;
        bd  = bus.oKESBound;
        for (int c = 0; c < 4; c++)
            if (g[c] && rem[c] > 0) rem[c] = rem[c] - 1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        av       = 2'b11;
        all_last = 1'b0;
        for (int c = 0; c < 4; c++) rem[c] = 0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] pool_g [8] = '{4'b0001, 4'b0010, 4'b0000, 4'b0001,
                               4'b0010, 4'b0000, 4'b0100, 4'b0010};

    initial begin
        n_vec               = 0;
        n_err               = 0;
        iReset              = 1'b0;
        bus.iRequestChannel = '0;
        bus.iLastChunk      = '0;
        bus.iKESAvail       = '0;

        // Reset state
        do_reset();
        check("rst_grant", 32'(g), 32'h0);
        check("rst_start", 32'(st), 32'h0);
        check("rst_chan", 32'(chs), 32'h0);
        check("rst_bound", 32'(bd), 32'h0);

        // Single channel 2, three chunks, KES1 untouched
        rem[2] = 3;
        tick();
        tick();
        check("t1_start1", 32'(st), 32'b01);
        check("t1_grant1", 32'(g), 32'b0100);
        check("t1_chan0", 32'(chs[1:0]), 32'd2);
        check("t1_bound1", 32'(bd), 32'b01);
        tick();
        check("t1_start_dummy", 32'(st), 32'b00);
        tick();
        tick();
        check("t1_start2", 32'(st), 32'b01);
        tick();
        tick();
        tick();
        check("t1_start3", 32'(st), 32'b01);
        tick();
        check("t1_bound_dummy", 32'(bd), 32'b01);
        tick();
        check("t1_bound_rel", 32'(bd), 32'b00);
        check("t1_chan_hold", 32'(chs[1:0]), 32'd2);

        // Two simultaneous requests from pointer 0
        do_reset();
        rem[0] = 1;
        rem[3] = 1;
        tick();
        tick();
        check("t2_start_k0", 32'(st), 32'b01);
        check("t2_grant_c0", 32'(g), 32'b0001);
        check("t2_chan_k0", 32'(chs[1:0]), 32'd0);
        tick();
        check("t2_start_k1", 32'(st), 32'b10);
        check("t2_grant_c3", 32'(g), 32'b1000);
        check("t2_chan_k1", 32'(chs[3:2]), 32'd3);
        tick();
        tick();
        tick();
        // Pointer must have wrapped back to 0: channel 0 beats channel 2
        rem[0] = 1;
        rem[2] = 1;
        tick();
        tick();
        check("t2_ptr_grant", 32'(g), 32'b0001);
        tick();
        check("t2_ptr_second", 32'(g), 32'b0100);

        // Fairness with a single usable KES and continuous single-chunk traffic
        do_reset();
        av       = 2'b01;
        all_last = 1'b1;
        for (int c = 0; c < 4; c++) rem[c] = 100;
        tick();
        for (int i = 0; i < 5; i++) begin
            repeat (i == 0 ? 1 : 3) tick();
            check($sformatf("fair_%0d", i), 32'(g), 32'(4'b0001 << (i % 4)));
        end

        // Pool exhausted: channel 2 waits for a slot to go Idle
        do_reset();
        rem[0] = 2;
        rem[1] = 3;
        rem[2] = 1;
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            check($sformatf("pool_grant_t%0d", k + 1), 32'(g), 32'(pool_g[k]));
            if (k == 1) check("pool_bound_both", 32'(bd), 32'b11);
            if (k == 6) check("pool_chan_k0", 32'(chs[1:0]), 32'd2);
            if (k == 7) check("pool_start_k1", 32'(st), 32'b10);
        end

        // Standby stall while KES0 is unavailable
        do_reset();
        rem[1] = 2;
        tick();
        tick();
        check("stall_first", 32'(g), 32'b0010);
        tick();
        av = 2'b10;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("stall_hold_%0d", i), 32'({bd, st}), 32'b0100);
        end
        av = 2'b11;
        tick();
        check("stall_return", 32'(st), 32'b00);
        tick();
        check("stall_reissue", 32'(st), 32'b01);
        check("stall_regrant", 32'(g), 32'b0010);

        // Reset while KES1 sits in Standby
        do_reset();
        av     = 2'b10;
        rem[3] = 3;
        tick();
        tick();
        check("rmid_start_k1", 32'(st), 32'b10);
        check("rmid_chan_k1", 32'(chs[3:2]), 32'd3);
        tick();
        rst_n = 1'b0;
        tick();
        check("rmid_standby", 32'(bd), 32'b10);
        for (int c = 0; c < 4; c++) rem[c] = 0;
        tick();
        check("rmid_grant0", 32'(g), 32'h0);
        check("rmid_start0", 32'(st), 32'h0);
        check("rmid_chan0", 32'(chs), 32'h0);
        check("rmid_bound0", 32'(bd), 32'h0);
        rst_n  = 1'b1;
        av     = 2'b11;
        rem[2] = 1;
        tick();
        tick();
        check("rmid_fresh_start", 32'(st), 32'b01);
        check("rmid_fresh_chan", 32'(chs[1:0]), 32'd2);
        check("rmid_fresh_grant", 32'(g), 32'b0100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
